// File: rtl/t06_lcd_cmd_sequencer.sv
// t06_lcd_cmd_sequencer
//   Responder for the game-control handshake. An init_cycle request streams the
//   panel power-up sequence; an en_update request repaints one CELL x CELL grid
//   cell with a solid RGB565 colour. Bytes go out on an 8080-style write-only bus,
//   two cycles per byte (SETUP: wrx low, HOLD: wrx high).
// Ports
//   clk, nrst                 clock, async active-low reset
//   init_cycle, en_update     level requests, sampled only in IDLE (init wins)
//   sync_reset                synchronous abort back to IDLE, no cmd_done
//   cell_x, cell_y, color     update target, latched when an update starts
//   cmd_done                  one-cycle completion pulse
//   busy                      high from the cycle after start through cmd_done
//   lcd_csx/dcx/wrx/rdx/data  panel bus (rdx tied high)
module t06_lcd_cmd_sequencer #(
  parameter int CELL      = 10,
  parameter int COORD_W   = 5,
  parameter int DELAY_CYC = 1200000
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               init_cycle,
  input  logic               en_update,
  input  logic               sync_reset,
  input  logic [COORD_W-1:0] cell_x,
  input  logic [COORD_W-1:0] cell_y,
  input  logic [15:0]        color,
  output logic               cmd_done,
  output logic               busy,
  output logic               lcd_csx,
  output logic               lcd_dcx,
  output logic               lcd_wrx,
  output logic               lcd_rdx,
  output logic [7:0]         lcd_data
);
  localparam int NPB = 2 * CELL * CELL;                       // pixel bytes per cell
  localparam int PW  = (NPB > 1) ? $clog2(NPB) : 1;
  localparam int DW  = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;

  typedef enum logic [2:0] {IDLE, INIT, DLY, WIN, PIX, DONE} state_t;

  state_t             state, ns;
  logic               ph, nph;                                // 0 = SETUP, 1 = HOLD
  logic [3:0]         idx, nidx;                              // byte index in INIT/WIN
  logic [DW-1:0]      dcnt, ndcnt;
  logic [PW-1:0]      pcnt, npcnt;
  logic [COORD_W-1:0] cx_q, cy_q, cx_n, cy_n;
  logic [15:0]        col_q, col_n;
  logic               start_upd;
  logic [15:0]        xs, xe, ys, ye;
  logic [8:0]         byte_n;                                 // {dcx, data}
  logic               csx_d, wrx_d, dcx_d, busy_d, done_d;
  logic [7:0]         data_d;

  assign lcd_rdx = 1'b1;

  // Next-state / counters
  always_comb begin
    ns        = state;
    nph       = ph;
    nidx      = idx;
    ndcnt     = dcnt;
    npcnt     = pcnt;
    start_upd = 1'b0;
    if (sync_reset) begin
      ns    = IDLE;
      nph   = 1'b0;
      nidx  = '0;
      ndcnt = '0;
      npcnt = '0;
    end else begin
      case (state)
        IDLE: begin
          nph   = 1'b0;
          nidx  = '0;
          ndcnt = '0;
          npcnt = '0;
          if (init_cycle)     ns = INIT;
          else if (en_update) begin
            ns        = WIN;
            start_upd = 1'b1;
          end
        end
        INIT: begin
          if (!ph) nph = 1'b1;
          else begin
            nph = 1'b0;
            if (idx == 4'd6)      ns = DONE;
            else if (idx <= 4'd1) begin                       // SWRESET / SLPOUT need a wait
              ns    = DLY;
              ndcnt = '0;
            end else nidx = idx + 4'd1;
          end
        end
        DLY: begin
          if (dcnt == DW'(DELAY_CYC - 1)) begin
            ns   = INIT;
            nidx = idx + 4'd1;
          end else ndcnt = dcnt + 1'b1;
        end
        WIN: begin
          if (!ph) nph = 1'b1;
          else begin
            nph = 1'b0;
            if (idx == 4'd10) begin
              ns    = PIX;
              npcnt = '0;
            end else nidx = idx + 4'd1;
          end
        end
        PIX: begin
          if (!ph) nph = 1'b1;
          else begin
            nph = 1'b0;
            if (pcnt == PW'(NPB - 1)) ns = DONE;
            else npcnt = pcnt + 1'b1;
          end
        end
        DONE:    ns = IDLE;
        default: ns = IDLE;
      endcase
    end
  end

  // Target values visible in the same cycle the update starts, so the first
  // window byte can be registered from the live inputs.
  assign cx_n  = start_upd ? cell_x : cx_q;
  assign cy_n  = start_upd ? cell_y : cy_q;
  assign col_n = start_upd ? color  : col_q;
  assign xs    = 16'(cx_n) * 16'(CELL);
  assign xe    = xs + 16'(CELL - 1);
  assign ys    = 16'(cy_n) * 16'(CELL);
  assign ye    = ys + 16'(CELL - 1);

  // Byte that the next cycle drives; DLY and DONE keep the last byte on the bus.
  always_comb begin
    byte_n = {lcd_dcx, lcd_data};
    case (ns)
      INIT: begin
        case (nidx)
          4'd0:    byte_n = 9'h001;
          4'd1:    byte_n = 9'h011;
          4'd2:    byte_n = 9'h03A;
          4'd3:    byte_n = 9'h155;
          4'd4:    byte_n = 9'h036;
          4'd5:    byte_n = 9'h148;
          default: byte_n = 9'h029;
        endcase
      end
      WIN: begin
        case (nidx)
          4'd0:    byte_n = 9'h02A;
          4'd1:    byte_n = {1'b1, xs[15:8]};
          4'd2:    byte_n = {1'b1, xs[7:0]};
          4'd3:    byte_n = {1'b1, xe[15:8]};
          4'd4:    byte_n = {1'b1, xe[7:0]};
          4'd5:    byte_n = 9'h02B;
          4'd6:    byte_n = {1'b1, ys[15:8]};
          4'd7:    byte_n = {1'b1, ys[7:0]};
          4'd8:    byte_n = {1'b1, ye[15:8]};
          4'd9:    byte_n = {1'b1, ye[7:0]};
          default: byte_n = 9'h02C;
        endcase
      end
      PIX:     byte_n = {1'b1, npcnt[0] ? col_n[7:0] : col_n[15:8]};
      default: byte_n = {lcd_dcx, lcd_data};
    endcase
  end

  // Output values for the next cycle, derived from the next state
  always_comb begin
    csx_d  = !(ns inside {INIT, DLY, WIN, PIX});
    wrx_d  = !((ns inside {INIT, WIN, PIX}) && !nph);
    busy_d = (ns != IDLE);
    done_d = (ns == DONE);
    {dcx_d, data_d} = (ns == IDLE) ? 9'h100 : byte_n;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      ph       <= 1'b0;
      idx      <= '0;
      dcnt     <= '0;
      pcnt     <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      col_q    <= '0;
      lcd_csx  <= 1'b1;
      lcd_wrx  <= 1'b1;
      lcd_dcx  <= 1'b1;
      lcd_data <= 8'h00;
      cmd_done <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= ns;
      ph       <= nph;
      idx      <= nidx;
      dcnt     <= ndcnt;
      pcnt     <= npcnt;
      cx_q     <= cx_n;
      cy_q     <= cy_n;
      col_q    <= col_n;
      lcd_csx  <= csx_d;
      lcd_wrx  <= wrx_d;
      lcd_dcx  <= dcx_d;
      lcd_data <= data_d;
      cmd_done <= done_d;
      busy     <= busy_d;
    end
  end
endmodule

// File: tb/tb_t06_lcd_cmd_sequencer.sv
// Bench for t06_lcd_cmd_sequencer: a per-cycle expected-trace model (queue of
// expected bus/handshake values built from the request rules) checked every
// cycle, directed scenarios pinned with literal byte lists and cmd_done times,
// then a randomized request phase.
module tb_t06_lcd_cmd_sequencer;
  localparam int CELL = 10;
  localparam int DLY  = 4;

  logic        clk = 1'b0, nrst = 1'b0;
  logic        init_cycle = 1'b0, en_update = 1'b0, sync_reset = 1'b0;
  logic [4:0]  cell_x = '0, cell_y = '0;
  logic [15:0] color = '0;
  logic        cmd_done, busy, lcd_csx, lcd_dcx, lcd_wrx, lcd_rdx;
  logic [7:0]  lcd_data;

  t06_lcd_cmd_sequencer #(.CELL(CELL), .COORD_W(5), .DELAY_CYC(DLY)) dut (
    .clk(clk), .nrst(nrst), .init_cycle(init_cycle), .en_update(en_update),
    .sync_reset(sync_reset), .cell_x(cell_x), .cell_y(cell_y), .color(color),
    .cmd_done(cmd_done), .busy(busy), .lcd_csx(lcd_csx), .lcd_dcx(lcd_dcx),
    .lcd_wrx(lcd_wrx), .lcd_rdx(lcd_rdx), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic csx, wrx, dcx;
    logic [7:0] data;
    logic busy, done, chk;   // chk: dcx/data are meaningful this cycle
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  bit         idle_now;
  bit         pr = 1'b1;     // next idle cycle must show reset bus values
  int         vectors = 0, errs = 0;
  logic [8:0] rec[$];        // DUT bytes captured on SETUP cycles
  int         dn[$];         // cycles where DUT raised cmd_done
  logic [8:0] init_exp[$], upd_exp[$];
  logic [8:0] init_tab [7] = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h148, 9'h029};
  logic [8:0] hdr_tab [11] = '{9'h02A, 9'h100, 9'h11E, 9'h100, 9'h127,
                               9'h02B, 9'h101, 9'h136, 9'h101, 9'h13F, 9'h02C};

  // ---- model: expected per-cycle trace of one request
  task automatic push_byte(input logic d, input logic [7:0] v);
    q.push_back('{csx:1'b0, wrx:1'b0, dcx:d, data:v, busy:1'b1, done:1'b0, chk:1'b1});
    q.push_back('{csx:1'b0, wrx:1'b1, dcx:d, data:v, busy:1'b1, done:1'b0, chk:1'b1});
  endtask

  task automatic push_done();
    q.push_back('{csx:1'b1, wrx:1'b1, dcx:1'b0, data:8'h00, busy:1'b1, done:1'b1, chk:1'b0});
  endtask

  task automatic push_init();
    for (int i = 0; i < 7; i++) begin
      push_byte(init_tab[i][8], init_tab[i][7:0]);
      if (i < 2)
        repeat (DLY) q.push_back('{csx:1'b0, wrx:1'b1, dcx:1'b0, data:8'h00,
                                   busy:1'b1, done:1'b0, chk:1'b0});
    end
    push_done();
  endtask

  task automatic push_upd(input logic [4:0] cx, input logic [4:0] cy, input logic [15:0] col);
    logic [15:0] xs, xe, ys, ye;
    xs = 16'(cx) * 16'(CELL); xe = xs + 16'(CELL - 1);
    ys = 16'(cy) * 16'(CELL); ye = ys + 16'(CELL - 1);
    push_byte(1'b0, 8'h2A);
    push_byte(1'b1, xs[15:8]); push_byte(1'b1, xs[7:0]);
    push_byte(1'b1, xe[15:8]); push_byte(1'b1, xe[7:0]);
    push_byte(1'b0, 8'h2B);
    push_byte(1'b1, ys[15:8]); push_byte(1'b1, ys[7:0]);
    push_byte(1'b1, ye[15:8]); push_byte(1'b1, ye[7:0]);
    push_byte(1'b0, 8'h2C);
    for (int p = 0; p < CELL * CELL; p++) begin
      push_byte(1'b1, col[15:8]);
      push_byte(1'b1, col[7:0]);
    end
    push_done();
  endtask

  // ---- per-cycle compare at the falling edge
  task automatic sample();
    @(negedge clk);
    if (q.size() != 0) begin
      e = q.pop_front();
      idle_now = 1'b0;
    end else begin
      e = '{csx:1'b1, wrx:1'b1, dcx:1'b1, data:8'h00, busy:1'b0, done:1'b0, chk:pr};
      pr = 1'b0;
      idle_now = 1'b1;
    end
    vectors++;
    if (lcd_csx !== e.csx || lcd_wrx !== e.wrx || busy !== e.busy || cmd_done !== e.done ||
        lcd_rdx !== 1'b1 || (e.chk && {lcd_dcx, lcd_data} !== {e.dcx, e.data})) begin
      errs++;
      $display("FAIL cycle_check cyc=%0d got csx=%b wrx=%b dcx=%b data=%h busy=%b done=%b rdx=%b want csx=%b wrx=%b dcx=%b data=%h busy=%b done=%b (dd %0s)",
               cyc, lcd_csx, lcd_wrx, lcd_dcx, lcd_data, busy, cmd_done, lcd_rdx,
               e.csx, e.wrx, e.dcx, e.data, e.busy, e.done, e.chk ? "checked" : "ignored");
    end
    if (!lcd_csx && !lcd_wrx) rec.push_back({lcd_dcx, lcd_data});
    if (cmd_done) dn.push_back(cyc);
  endtask

  // ---- drive inputs for this cycle and advance the model
  task automatic apply(input bit i_init, input bit i_upd, input bit i_sr,
                       input logic [4:0] cx, input logic [4:0] cy, input logic [15:0] col);
    init_cycle = i_init; en_update = i_upd; sync_reset = i_sr;
    cell_x = cx; cell_y = cy; color = col;
    if (i_sr) begin
      q.delete();
      pr = 1'b1;
    end else if (idle_now) begin
      if (i_init)     push_init();
      else if (i_upd) push_upd(cx, cy, col);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  task automatic chk_list(input string name, input logic [8:0] want[$]);
    int bad;
    bad = -1;
    for (int i = 0; i < want.size() && i < rec.size(); i++)
      if (bad < 0 && rec[i] !== want[i]) bad = i;
    vectors++;
    if (rec.size() != want.size() || bad >= 0) begin
      errs++;
      if (bad >= 0)
        $display("FAIL %s: byte %0d got %h want %h (len got %0d want %0d)",
                 name, bad, rec[bad], want[bad], rec.size(), want.size());
      else
        $display("FAIL %s: length got %0d want %0d", name, rec.size(), want.size());
    end
  endtask

  // Request held until cmd_done is seen, dropped in that same cycle.
  task automatic run_req(input bit ri, input bit ru, input logic [4:0] cx, input logic [4:0] cy,
                         input logic [15:0] col, input bit perturb, output int start);
    bit got;
    rec.delete(); dn.delete();
    sample();
    start = cyc;
    apply(ri, ru, 1'b0, cx, cy, col);
    got = 1'b0;
    for (int n = 0; n < 1000 && !got; n++) begin
      sample();
      if (e.done) begin
        got = 1'b1;
        apply(1'b0, 1'b0, 1'b0, cx, cy, col);
      end else
        apply(ri, ru, 1'b0, perturb ? ~cx : cx, perturb ? cy + 5'd7 : cy, perturb ? ~col : col);
    end
    if (!got) chk_int("request_timeout", 0, 1);
  endtask

  int  st;
  bit  hi, hu, sr;
  int  r;

  initial begin
    foreach (init_tab[i]) init_exp.push_back(init_tab[i]);
    foreach (hdr_tab[i]) upd_exp.push_back(hdr_tab[i]);
    for (int p = 0; p < CELL * CELL; p++) begin
      upd_exp.push_back(9'h1F8);
      upd_exp.push_back(9'h100);
    end

    // reset state
    repeat (3) begin sample(); pr = 1'b1; apply(0, 0, 0, '0, '0, '0); end
    nrst = 1'b1;
    repeat (2) begin sample(); apply(0, 0, 0, '0, '0, '0); end

    // init sequence
    run_req(1, 0, 5'd0, 5'd0, 16'h0, 0, st);
    chk_list("init_bytes", init_exp);
    chk_int("init_done_count", dn.size(), 1);
    chk_int("init_done_cyc", dn.size() > 0 ? dn[0] - st : -1, 23);

    // both requests together: init wins
    run_req(1, 1, 5'd3, 5'd31, 16'hF800, 0, st);
    chk_list("both_bytes", init_exp);
    chk_int("both_done_cyc", dn.size() > 0 ? dn[0] - st : -1, 23);

    // update with inputs changed mid-stream
    run_req(0, 1, 5'd3, 5'd31, 16'hF800, 1, st);
    chk_list("upd_bytes", upd_exp);
    chk_int("upd_done_count", dn.size(), 1);
    chk_int("upd_done_cyc", dn.size() > 0 ? dn[0] - st : -1, 423);

    // sync_reset on pixel byte 40
    rec.delete(); dn.delete();
    sample(); st = cyc;
    apply(0, 1, 0, 5'd1, 5'd1, 16'hABCD);
    for (int k = 1; k < 103; k++) begin sample(); apply(0, 1, 0, 5'd1, 5'd1, 16'hABCD); end
    sample();
    chk_int("pix40_byte", {lcd_dcx, lcd_data}, 9'h1AB);
    apply(0, 0, 1, 5'd1, 5'd1, 16'hABCD);
    repeat (40) begin sample(); apply(0, 0, 0, '0, '0, '0); end
    chk_int("sr_no_done", dn.size(), 0);
    run_req(0, 1, 5'd7, 5'd4, 16'h07E0, 0, st);
    chk_int("sr_restart_first", rec.size() > 0 ? int'(rec[0]) : -1, 9'h02A);
    chk_int("sr_restart_len", rec.size(), 211);
    chk_int("sr_restart_done_cyc", dn.size() > 0 ? dn[0] - st : -1, 423);

    // sync_reset beats a start in IDLE
    dn.delete();
    sample(); apply(1, 1, 1, 5'd2, 5'd2, 16'h1111);
    repeat (5) begin sample(); apply(0, 0, 0, '0, '0, '0); end
    chk_int("sr_idle_no_done", dn.size(), 0);

    // nrst during DELAY
    dn.delete();
    sample(); st = cyc;
    apply(1, 0, 0, '0, '0, '0);
    repeat (4) begin sample(); apply(1, 0, 0, '0, '0, '0); end
    nrst = 1'b0;
    #1;
    chk_int("nrst_async_outputs",
            {lcd_csx, lcd_wrx, lcd_rdx, lcd_dcx, lcd_data, cmd_done, busy}, 14'h3C00);
    q.delete(); pr = 1'b1;
    repeat (3) begin sample(); apply(0, 0, 0, '0, '0, '0); end
    nrst = 1'b1;
    chk_int("nrst_no_done", dn.size(), 0);
    run_req(1, 0, '0, '0, '0, 0, st);
    chk_list("nrst_restart_bytes", init_exp);
    chk_int("nrst_restart_done_cyc", dn.size() > 0 ? dn[0] - st : -1, 23);

    // randomized requests, junk while busy, rare aborts
    hi = 0; hu = 0;
    for (int n = 0; n < 8000; n++) begin
      sample();
      sr = ($urandom_range(0, 299) == 0);
      if (idle_now) begin
        r  = $urandom_range(0, 11);
        hi = (r < 2);
        hu = (r < 6) && (r >= 1);
      end else if (e.done) begin
        hi = 0; hu = 0;
      end else if ($urandom_range(0, 15) == 0) begin
        hi = 1'($urandom); hu = 1'($urandom);
      end
      apply(hi, hu, sr, 5'($urandom), 5'($urandom), 16'($urandom));
    end
    apply(0, 0, 0, '0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
